// File: rtl/uart_tx_queue_if.sv
// Bus-side write port and transmitter launch handshake of the UART TX byte queue.
interface uart_tx_queue_if #(parameter int DEPTH = 8);
  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     ovf_clr;
  logic                     tx_done;
  logic                     trmt;
  logic [7:0]               tx_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;

  modport slave  (input  wr_en, wr_data, ovf_clr, tx_done,
                  output trmt, tx_data, full, empty, count, ovf);
  modport master (output wr_en, wr_data, ovf_clr, tx_done,
                  input  trmt, tx_data, full, empty, count, ovf);
endinterface

// File: rtl/uart_tx_queue.sv
// DEPTH-entry byte FIFO feeding the UART transmitter one byte per frame via
// a registered trmt pulse; sticky ovf records writes dropped while full.
module uart_tx_queue #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_DONE} state_t;

  state_t        state, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf, trmt, wait_first;
  logic [7:0]    tx_data;
  logic          full, empty, wr_acc, wr_drop, pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_acc  = bus.wr_en && !full;
  assign wr_drop = bus.wr_en && full;

  // tx_done from the previous frame may still be visible in the first
  // WAIT_DONE cycle, so that cycle's evaluation ignores it.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE:      if (!empty) begin
                   pop     = 1'b1;
                   state_d = ARM;
                 end
      ARM:       state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done && !wait_first) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_first <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      state      <= state_d;
      wait_first <= (state == ARM);
      trmt       <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_drop)          ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.trmt    = trmt;
  assign bus.tx_data = tx_data;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.count   = count;
  assign bus.ovf     = ovf;
endmodule
